rr_priority_encoder: RTL

//   Parametrised, registered priority encoder with a valid/ready handshake on both sides.
//   Two modes:
//     - fixed priority: lowest index wins.
//     - round-robin: search starts at a rotating pointer and wraps.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_lsb_find.sv | 28 ++
 rtl/rr_priority_encoder.sv | 86 ++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package pe_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/pe_lsb_find.sv
// Combinational lowest-set-bit finder: found flag, isolated one-hot bit and binary index.
module pe_lsb_find
    import pe_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int IDXW  = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  idx
);

    assign found  = |vec;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (-vec);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder (fixed or round-robin) with valid/ready on both sides.
module rr_priority_encoder
    import pe_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int IDXW  = clog2(WIDTH),
    parameter int MODE  = MODE_RR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_bits,
    output logic             req_ready,
    output logic             grant_valid,
    output logic             grant_any,
    output logic [WIDTH-1:0] grant_onehot,
    output logic [IDXW-1:0]  grant_idx,
    input  logic             grant_ready
);

    logic [IDXW-1:0]  ptr;
    logic [WIDTH-1:0] masked;
    logic             masked_found;
    logic [WIDTH-1:0] masked_onehot;
    logic [IDXW-1:0]  masked_idx;
    logic             full_found;
    logic [WIDTH-1:0] full_onehot;
    logic [IDXW-1:0]  full_idx;
    logic             win_any;
    logic [WIDTH-1:0] win_onehot;
    logic [IDXW-1:0]  win_idx;
    logic             accept;

    assign req_ready = !grant_valid || grant_ready;
    assign accept    = req_valid && req_ready;

    // Bits below the pointer are skipped first; the unmasked search covers the wrap.
    assign masked = req_bits & ({WIDTH{1'b1}} << ptr);

    pe_lsb_find #(.WIDTH(WIDTH), .IDXW(IDXW)) u_masked (
        .vec    (masked),
        .found  (masked_found),
        .onehot (masked_onehot),
        .idx    (masked_idx)
    );

    pe_lsb_find #(.WIDTH(WIDTH), .IDXW(IDXW)) u_full (
        .vec    (req_bits),
        .found  (full_found),
        .onehot (full_onehot),
        .idx    (full_idx)
    );

    always_comb begin
        win_any    = full_found;
        win_onehot = full_onehot;
        win_idx    = full_idx;
        if (MODE == MODE_RR && masked_found) begin
            win_onehot = masked_onehot;
            win_idx    = masked_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid  <= 1'b0;
            grant_any    <= 1'b0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            ptr          <= '0;
        end else if (accept) begin
            grant_valid  <= 1'b1;
            grant_any    <= win_any;
            grant_onehot <= win_onehot;
            grant_idx    <= win_idx;
            // IDXW-bit wrap gives (winner + 1) mod WIDTH since WIDTH is a power of two.
            if (MODE == MODE_RR && win_any) begin
                ptr <= win_idx + IDXW'(1);
            end
        end else if (grant_ready) begin
            grant_valid <= 1'b0;
        end
    end

endmodule
